// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for the 32x32 select/strobe register file.
// Runs one WRITE/READ/COPY/CLEAR command at a time and returns a single response beat.
module regfile_access_ctrl #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int DEPTH  = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr_a,
   input  logic [AW-1:0] cmd_addr_b,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          busy,
   output logic [DW-1:0] rf_inp,
   output logic [AW-1:0] rf_selin,
   output logic [AW-1:0] rf_selout,
   output logic          rf_read,
   output logic          rf_write,
   output logic          rf_en,
   input  logic [DW-1:0] rf_out
);

   // state  | meaning
   // IDLE   | cmd_ready high, waiting for a command
   // WR     | single write strobe with the command data
   // RD     | single read strobe on addr_a
   // RWAIT  | waiting RD_LAT cycles for rf_out, captured on the last one
   // CWR    | COPY: write captured data to addr_b
   // CLR    | DEPTH zero writes, then one settle cycle before responding
   // RESP   | rsp_valid held until rsp_ready
   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_CWR, S_CLR, S_RESP} state_t;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam int         CW       = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [2:0]    RD_LAT_C = 3'(RD_LAT);

   state_t        state, state_nxt;
   logic [CW-1:0] clr_cnt, clr_nxt;
   logic [2:0]    wait_cnt, wait_nxt;
   logic [1:0]    op_q;
   logic [AW-1:0] addr_b_q;
   logic          accept, capture;

   logic          cmd_ready_d, rsp_valid_d, busy_d, rf_read_d, rf_write_d;
   logic [DW-1:0] rsp_data_d, rf_inp_d;
   logic [AW-1:0] rf_selin_d, rf_selout_d;

   assign accept  = (state == S_IDLE) && cmd_valid && cmd_ready;
   assign capture = (state == S_RWAIT) && (wait_cnt == 3'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         clr_cnt  <= '0;
         wait_cnt <= '0;
         op_q     <= '0;
         addr_b_q <= '0;
      end else begin
         state    <= state_nxt;
         clr_cnt  <= clr_nxt;
         wait_cnt <= wait_nxt;
         if (accept) begin
            op_q     <= cmd_op;
            addr_b_q <= cmd_addr_b;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_cnt;
      wait_nxt  = wait_cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_WRITE: state_nxt = S_WR;
                  OP_READ,
                  OP_COPY:  state_nxt = S_RD;
                  default: begin
                     state_nxt = S_CLR;
                     clr_nxt   = '0;
                  end
               endcase
            end
         end
         S_WR:  state_nxt = S_RESP;
         S_RD: begin
            state_nxt = S_RWAIT;
            wait_nxt  = RD_LAT_C;
         end
         S_RWAIT: begin
            wait_nxt = wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) state_nxt = (op_q == OP_COPY) ? S_CWR : S_RESP;
         end
         S_CWR: state_nxt = S_RESP;
         S_CLR: begin
            if (clr_cnt == DEPTH_C) state_nxt = S_RESP;
            else                    clr_nxt   = clr_cnt + CW'(1);
         end
         S_RESP: if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so each strobe appears in the cycle of its state.
   always_comb begin
      cmd_ready_d = (state_nxt == S_IDLE);
      busy_d      = (state_nxt != S_IDLE);
      rsp_valid_d = (state_nxt == S_RESP);
      rf_read_d   = (state_nxt == S_RD);
      rf_write_d  = (state_nxt == S_WR) || (state_nxt == S_CWR) ||
                    ((state_nxt == S_CLR) && (clr_nxt != DEPTH_C));
      rf_inp_d    = rf_inp;
      rf_selin_d  = rf_selin;
      rf_selout_d = rf_selout;
      rsp_data_d  = rsp_data;
      if (state_nxt == S_WR) begin
         rf_selin_d = cmd_addr_a;
         rf_inp_d   = cmd_wdata;
      end
      if (state_nxt == S_RD) rf_selout_d = cmd_addr_a;
      if (state == S_WR) rsp_data_d = rf_inp;
      if (capture) begin
         rsp_data_d = rf_out;
         if (state_nxt == S_CWR) begin
            rf_selin_d = addr_b_q;
            rf_inp_d   = rf_out;
         end
      end
      if ((state_nxt == S_CLR) && (clr_nxt != DEPTH_C)) begin
         rf_selin_d = AW'(clr_nxt);
         rf_inp_d   = '0;
      end
      if ((state == S_CLR) && (state_nxt == S_RESP)) rsp_data_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rf_inp    <= '0;
         rf_selin  <= '0;
         rf_selout <= '0;
         rf_read   <= 1'b0;
         rf_write  <= 1'b0;
         rf_en     <= 1'b0;
      end else begin
         cmd_ready <= cmd_ready_d;
         busy      <= busy_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rf_inp    <= rf_inp_d;
         rf_selin  <= rf_selin_d;
         rf_selout <= rf_selout_d;
         rf_read   <= rf_read_d;
         rf_write  <= rf_write_d;
         rf_en     <= rf_read_d | rf_write_d;
      end
   end

endmodule
